rx_aligner: RTL and testbench



---
 rtl/rx_aligner_pkg.sv | 26 ++
 rtl/rx_aligner.sv | 164 ++++++++++++++++
 tb/tb_rx_aligner.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_aligner_pkg.sv
// Shared types and constants for the PCIe RX stream aligner.
package ofs_fim_pcie_rx_pkg;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 256;
  localparam int USER_W = 10;
  localparam int CH0    = 0;
  localparam int CH1    = 1;

  typedef struct packed {
    logic              valid;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
  } t_rx_ch;

  typedef t_rx_ch [NUM_CH-1:0] t_rx_beat;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } t_state;

endpackage

// File: rtl/rx_aligner.sv
// Re-packs the 2-channel RX stream so every SOP sits on CH0 and no beat mixes TLPs.
module rx_aligner
  import ofs_fim_pcie_rx_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rx_tvalid,
  output logic                     o_rx_tready,
  input  logic [NUM_CH-1:0]        i_rx_valid,
  input  logic [NUM_CH-1:0]        i_rx_sop,
  input  logic [NUM_CH-1:0]        i_rx_eop,
  input  logic [NUM_CH*DATA_W-1:0] i_rx_data,
  input  logic [NUM_CH*USER_W-1:0] i_rx_user,
  output logic                     o_rx_tvalid,
  input  logic                     i_rx_tready,
  output logic [NUM_CH-1:0]        o_rx_valid,
  output logic [NUM_CH-1:0]        o_rx_sop,
  output logic [NUM_CH-1:0]        o_rx_eop,
  output logic [NUM_CH*DATA_W-1:0] o_rx_data,
  output logic [NUM_CH*USER_W-1:0] o_rx_user,
  output logic                     o_err,
  output logic [1:0]               dbg_state,
  output logic                     dbg_hold_vld
);

  // Handshake: a beat moves on a clock edge where tvalid & tready are both high;
  // tvalid never waits on tready, and a presented beat stays stable until taken.

  t_state   state_q, state_d;
  t_rx_ch   hold_q, hold_d;
  logic     hold_vld_q, hold_vld_d;
  t_rx_beat out_q, out_d;
  logic     out_tvalid_q, out_tvalid_d;
  logic     err_q, err_d;
  logic     open_q, open_d;
  t_rx_beat in_beat;
  logic     out_free, acc, take, split;
  logic     open_mid, sop_err;

  // Flags of an invalid channel are masked so they can never leak to the output.
  always_comb begin
    in_beat = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      in_beat[ch].valid = i_rx_valid[ch];
      in_beat[ch].sop   = i_rx_sop[ch] & i_rx_valid[ch];
      in_beat[ch].eop   = i_rx_eop[ch] & i_rx_valid[ch];
      in_beat[ch].data  = i_rx_data[ch*DATA_W +: DATA_W];
      in_beat[ch].user  = i_rx_user[ch*USER_W +: USER_W];
    end
  end

  assign out_free    = ~out_tvalid_q | i_rx_tready;
  assign o_rx_tready = out_free & (state_q != FLUSH);
  assign acc         = i_rx_tvalid & o_rx_tready;
  assign take        = acc & (|i_rx_valid);
  assign split       = in_beat[CH0].eop & in_beat[CH1].sop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PASS;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      out_q        <= '0;
      out_tvalid_q <= 1'b0;
      err_q        <= 1'b0;
      open_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      out_q        <= out_d;
      out_tvalid_q <= out_tvalid_d;
      err_q        <= err_d;
      open_q       <= open_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PASS:    if (take && split) state_d = in_beat[CH1].eop ? FLUSH : SHIFT;
      SHIFT:   if (take) state_d = !in_beat[CH1].valid ? PASS :
                                   (in_beat[CH1].eop ? FLUSH : SHIFT);
      FLUSH:   if (out_free) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_comb begin
    out_d        = out_q;
    out_tvalid_d = out_tvalid_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    if (out_free) begin
      out_d        = '0;
      out_tvalid_d = 1'b0;
      unique case (state_q)
        PASS: if (take) begin
          out_tvalid_d = 1'b1;
          out_d        = in_beat;
          if (split) begin
            out_d[CH1] = '0;
            hold_d     = in_beat[CH1];
            hold_vld_d = 1'b1;
          end
        end
        SHIFT: if (take) begin
          out_tvalid_d = 1'b1;
          out_d[CH0]   = hold_q;
          out_d[CH1]   = in_beat[CH0];
          if (in_beat[CH1].valid) hold_d = in_beat[CH1];
          else                    hold_vld_d = 1'b0;
        end
        FLUSH: begin
          out_tvalid_d = 1'b1;
          out_d[CH0]   = hold_q;
          hold_vld_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // open tracks whether the input stream is inside a TLP, channel by channel.
  always_comb begin
    open_mid = in_beat[CH0].valid ? ~in_beat[CH0].eop : open_q;
    sop_err  = (in_beat[CH0].sop & open_q) | (in_beat[CH1].sop & open_mid);
    open_d   = open_q;
    err_d    = err_q;
    if (take) begin
      open_d = in_beat[CH1].valid ? ~in_beat[CH1].eop : open_mid;
      if ((in_beat[CH1].valid & ~in_beat[CH0].valid) | sop_err |
          ((state_q == SHIFT) & ~in_beat[CH0].valid))
        err_d = 1'b1;
    end
  end

  always_comb begin
    o_rx_valid = '0;
    o_rx_sop   = '0;
    o_rx_eop   = '0;
    o_rx_data  = '0;
    o_rx_user  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      o_rx_valid[ch]                  = out_q[ch].valid;
      o_rx_sop[ch]                    = out_q[ch].sop;
      o_rx_eop[ch]                    = out_q[ch].eop;
      o_rx_data[ch*DATA_W +: DATA_W]  = out_q[ch].data;
      o_rx_user[ch*USER_W +: USER_W]  = out_q[ch].user;
    end
  end

  assign o_rx_tvalid  = out_tvalid_q;
  assign o_err        = err_q;
  assign dbg_state    = state_q;
  assign dbg_hold_vld = hold_vld_q;

  // Once malformed input has been flagged, the forwarded beats may break these.
  a_no_sop_ch1: assert property (@(posedge clk) disable iff (rst || err_q)
    !o_rx_sop[CH1]);
  a_ch1_cont: assert property (@(posedge clk) disable iff (rst || err_q)
    o_rx_valid[CH1] |-> (o_rx_valid[CH0] & ~o_rx_eop[CH0]));

endmodule

// File: tb/tb_rx_aligner.sv
// Self-checking bench for rx_aligner: directed split/align cases plus randomized packed TLPs.
module tb_rx_aligner;
  import ofs_fim_pcie_rx_pkg::*;

  localparam int BW = 6 + NUM_CH*DATA_W + NUM_CH*USER_W;

  logic                     clk;
  logic                     rst;
  logic                     i_rx_tvalid;
  logic                     o_rx_tready;
  logic [NUM_CH-1:0]        i_rx_valid, i_rx_sop, i_rx_eop;
  logic [NUM_CH*DATA_W-1:0] i_rx_data;
  logic [NUM_CH*USER_W-1:0] i_rx_user;
  logic                     o_rx_tvalid;
  logic                     i_rx_tready;
  logic [NUM_CH-1:0]        o_rx_valid, o_rx_sop, o_rx_eop;
  logic [NUM_CH*DATA_W-1:0] o_rx_data;
  logic [NUM_CH*USER_W-1:0] o_rx_user;
  logic                     o_err;
  logic [1:0]               dbg_state;
  logic                     dbg_hold_vld;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  bit rdy_rand  = 0;
  bit rdy_fixed = 1;

  rx_aligner dut (
    .clk(clk), .rst(rst),
    .i_rx_tvalid(i_rx_tvalid), .o_rx_tready(o_rx_tready),
    .i_rx_valid(i_rx_valid), .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop),
    .i_rx_data(i_rx_data), .i_rx_user(i_rx_user),
    .o_rx_tvalid(o_rx_tvalid), .i_rx_tready(i_rx_tready),
    .o_rx_valid(o_rx_valid), .o_rx_sop(o_rx_sop), .o_rx_eop(o_rx_eop),
    .o_rx_data(o_rx_data), .o_rx_user(o_rx_user),
    .o_err(o_err), .dbg_state(dbg_state), .dbg_hold_vld(dbg_hold_vld)
  );

  // ---------------- clock / ready generation ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    i_rx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_rx_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Beat image with payload of invalid channels zeroed; flags are kept raw.
  function automatic logic [BW-1:0] mk_beat(input logic [1:0] v, input logic [1:0] s,
                                            input logic [1:0] e,
                                            input logic [2*DATA_W-1:0] d,
                                            input logic [2*USER_W-1:0] u);
    logic [2*DATA_W-1:0] dm;
    logic [2*USER_W-1:0] um;
    dm = d;
    um = u;
    for (int ch = 0; ch < 2; ch++) begin
      if (!v[ch]) begin
        dm[ch*DATA_W +: DATA_W] = '0;
        um[ch*USER_W +: USER_W] = '0;
      end
    end
    return {v, s, e, dm, um};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [USER_W-1:0] rnd_user();
    return USER_W'($urandom);
  endfunction

  // Output monitor: records every beat taken by the downstream side.
  always @(negedge clk) begin
    if (!rst && o_rx_tvalid && i_rx_tready)
      got_q.push_back(mk_beat(o_rx_valid, o_rx_sop, o_rx_eop, o_rx_data, o_rx_user));
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                            input logic [2*DATA_W-1:0] d, input logic [2*USER_W-1:0] u);
    bit done;
    done        = 0;
    i_rx_tvalid = 1'b1;
    i_rx_valid  = v;
    i_rx_sop    = s;
    i_rx_eop    = e;
    i_rx_data   = d;
    i_rx_user   = u;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (o_rx_tready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    i_rx_tvalid = 1'b0;
    i_rx_valid  = '0;
    i_rx_sop    = '0;
    i_rx_eop    = '0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drive_accept got=not_accepted required=accepted");
    end
  endtask

  task automatic wait_out(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL wait_out got=%0d beats required=%0d", got_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_rx_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b required=0", o_rx_tvalid); end
    checks++; if (o_rx_valid !== 2'b00) begin errors++; $display("FAIL rst_valid got=%b required=00", o_rx_valid); end
    checks++; if (o_rx_sop !== 2'b00)   begin errors++; $display("FAIL rst_sop got=%b required=00", o_rx_sop); end
    checks++; if (o_rx_eop !== 2'b00)   begin errors++; $display("FAIL rst_eop got=%b required=00", o_rx_eop); end
    checks++; if (o_err !== 1'b0)       begin errors++; $display("FAIL rst_err got=%b required=0", o_err); end
    checks++; if (dbg_state !== 2'd0)   begin errors++; $display("FAIL rst_state got=%0d required=0", dbg_state); end
    checks++; if (dbg_hold_vld !== 1'b0) begin errors++; $display("FAIL rst_hold got=%b required=0", dbg_hold_vld); end
    checks++; if (o_rx_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got=%b required=1", o_rx_tready); end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    checks++; if (o_rx_tvalid !== 1'b0) begin errors++; $display("FAIL post_rst_tvalid got=%b required=0", o_rx_tvalid); end
  endtask

  task automatic test_aligned();
    logic [DATA_W-1:0] d0, d1, d2, d3;
    logic [USER_W-1:0] u0, u1, u2, u3;
    logic [BW-1:0] g, x;
    d0 = rnd_data(); d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
    u0 = rnd_user(); u1 = rnd_user(); u2 = rnd_user(); u3 = rnd_user();
    got_q.delete(); exp_q.delete();
    exp_q.push_back(mk_beat(2'b11, 2'b01, 2'b00, {d1, d0}, {u1, u0}));
    exp_q.push_back(mk_beat(2'b11, 2'b00, 2'b10, {d3, d2}, {u3, u2}));
    drive_beat(2'b11, 2'b01, 2'b00, {d1, d0}, {u1, u0});
    checks++; if (o_rx_tvalid !== 1'b1) begin errors++; $display("FAIL aligned_latency got=%b required=1", o_rx_tvalid); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL aligned_state1 got=%0d required=0", dbg_state); end
    drive_beat(2'b11, 2'b00, 2'b10, {d3, d2}, {u3, u2});
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL aligned_state2 got=%0d required=0", dbg_state); end
    wait_out(2, 50);
    for (int i = 0; i < 2; i++) begin
      x = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      checks++;
      if (g !== x) begin errors++; $display("FAIL aligned_beat%0d got=%h required=%h", i, g, x); end
    end
  endtask

  task automatic test_split_single();
    logic [DATA_W-1:0] da, db;
    logic [USER_W-1:0] ua, ub;
    logic [BW-1:0] g, x;
    da = rnd_data(); db = rnd_data(); ua = rnd_user(); ub = rnd_user();
    got_q.delete(); exp_q.delete();
    exp_q.push_back(mk_beat(2'b01, 2'b01, 2'b01, {DATA_W'(0), da}, {USER_W'(0), ua}));
    exp_q.push_back(mk_beat(2'b01, 2'b01, 2'b01, {DATA_W'(0), db}, {USER_W'(0), ub}));
    drive_beat(2'b11, 2'b11, 2'b11, {db, da}, {ub, ua});
    @(negedge clk);
    checks++; if (o_rx_tready !== 1'b0) begin errors++; $display("FAIL flush_tready got=%b required=0", o_rx_tready); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL flush_state got=%0d required=2", dbg_state); end
    wait_out(2, 50);
    idle(4);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL split_single_count got=%0d required=2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      x = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      checks++;
      if (g !== x) begin errors++; $display("FAIL split_single_beat%0d got=%h required=%h", i, g, x); end
    end
  endtask

  task automatic test_split_multi();
    logic [DATA_W-1:0] da, c0, c1, c2;
    logic [USER_W-1:0] ua, v0, v1, v2;
    logic [BW-1:0] g, x;
    da = rnd_data(); c0 = rnd_data(); c1 = rnd_data(); c2 = rnd_data();
    ua = rnd_user(); v0 = rnd_user(); v1 = rnd_user(); v2 = rnd_user();
    got_q.delete(); exp_q.delete();
    exp_q.push_back(mk_beat(2'b01, 2'b01, 2'b01, {DATA_W'(0), da}, {USER_W'(0), ua}));
    exp_q.push_back(mk_beat(2'b11, 2'b01, 2'b00, {c1, c0}, {v1, v0}));
    exp_q.push_back(mk_beat(2'b01, 2'b00, 2'b01, {DATA_W'(0), c2}, {USER_W'(0), v2}));
    drive_beat(2'b11, 2'b11, 2'b01, {c0, da}, {v0, ua});
    drive_beat(2'b11, 2'b00, 2'b10, {c2, c1}, {v2, v1});
    wait_out(3, 50);
    idle(4);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL split_multi_count got=%0d required=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      x = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      checks++;
      if (g !== x) begin errors++; $display("FAIL split_multi_beat%0d got=%h required=%h", i, g, x); end
    end
  endtask

  // Reference: each TLP's entries, in order, packed two per beat starting at CH0.
  task automatic test_random();
    logic [DATA_W-1:0] ed[$];
    logic [USER_W-1:0] eu[$];
    bit es[$];
    bit ee[$];
    logic [BW-1:0] g, x;
    logic [1:0] gv, gs, ge;
    int nb;
    got_q.delete(); exp_q.delete();
    for (int t = 0; t < 1000; t++) begin
      int len;
      int base;
      len  = $urandom_range(1, 8);
      base = ed.size();
      for (int k = 0; k < len; k++) begin
        ed.push_back(rnd_data());
        eu.push_back(rnd_user());
        es.push_back(k == 0);
        ee.push_back(k == len - 1);
      end
      for (int k = 0; k < len; k += 2) begin
        if (k + 1 < len)
          exp_q.push_back(mk_beat(2'b11, {1'b0, k == 0}, {k + 1 == len - 1, 1'b0},
                                  {ed[base+k+1], ed[base+k]}, {eu[base+k+1], eu[base+k]}));
        else
          exp_q.push_back(mk_beat(2'b01, {1'b0, k == 0}, 2'b01,
                                  {DATA_W'(0), ed[base+k]}, {USER_W'(0), eu[base+k]}));
      end
    end
    nb = exp_q.size();
    rdy_rand = 1;
    for (int i = 0; i < ed.size(); i += 2) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) idle(1);
      else if (r < 15) drive_beat(2'b00, 2'b00, 2'b00, '0, '0);
      if (i + 1 < ed.size())
        drive_beat(2'b11, {es[i+1], es[i]}, {ee[i+1], ee[i]}, {ed[i+1], ed[i]}, {eu[i+1], eu[i]});
      else
        drive_beat(2'b01, {1'b0, es[i]}, {1'b0, ee[i]}, {DATA_W'(0), ed[i]}, {USER_W'(0), eu[i]});
    end
    wait_out(nb, 10000);
    rdy_rand = 0;
    idle(4);
    checks++; if (got_q.size() != nb) begin errors++; $display("FAIL random_count got=%0d required=%0d", got_q.size(), nb); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      x  = exp_q.pop_front();
      g  = got_q.pop_front();
      gv = g[BW-1 -: 2];
      gs = g[BW-3 -: 2];
      ge = g[BW-5 -: 2];
      checks++;
      if (g !== x) begin errors++; $display("FAIL random_beat got=%h required=%h", g, x); end
      checks++;
      if (gs[1] !== 1'b0) begin errors++; $display("FAIL random_sop_ch1 got=%b required=0", gs[1]); end
      checks++;
      if (gv[1] && !(gv[0] && !ge[0])) begin
        errors++; $display("FAIL random_mixed got=v%b e%b required=ch0_open", gv, ge);
      end
    end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL random_err got=%b required=0", o_err); end
  endtask

  task automatic test_err();
    got_q.delete();
    drive_beat(2'b10, 2'b10, 2'b10, {rnd_data(), DATA_W'(0)}, {rnd_user(), USER_W'(0)});
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b required=1", o_err); end
    idle(10);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b required=1", o_err); end
    drive_beat(2'b11, 2'b01, 2'b10, {rnd_data(), rnd_data()}, {rnd_user(), rnd_user()});
    idle(3);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky2 got=%b required=1", o_err); end
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d0, d1;
    logic [USER_W-1:0] u0, u1;
    logic [BW-1:0] g, x;
    rdy_fixed = 0;
    idle(2);
    drive_beat(2'b11, 2'b11, 2'b01, {rnd_data(), rnd_data()}, {rnd_user(), rnd_user()});
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid_state got=%0d required=1", dbg_state); end
    checks++; if (dbg_hold_vld !== 1'b1) begin errors++; $display("FAIL mid_hold got=%b required=1", dbg_hold_vld); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (o_rx_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid got=%b required=0", o_rx_tvalid); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state got=%0d required=0", dbg_state); end
    checks++; if (dbg_hold_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got=%b required=0", dbg_hold_vld); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got=%b required=0", o_err); end
    @(negedge clk);
    rst = 1'b0;
    rdy_fixed = 1;
    got_q.delete();
    idle(4);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_no_partial got=%0d required=0", got_q.size()); end
    d0 = rnd_data(); d1 = rnd_data(); u0 = rnd_user(); u1 = rnd_user();
    x = mk_beat(2'b11, 2'b01, 2'b10, {d1, d0}, {u1, u0});
    drive_beat(2'b11, 2'b01, 2'b10, {d1, d0}, {u1, u0});
    wait_out(1, 50);
    g = (got_q.size() > 0) ? got_q.pop_front() : '0;
    checks++; if (g !== x) begin errors++; $display("FAIL mid_first_beat got=%h required=%h", g, x); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst         = 1'b1;
    i_rx_tvalid = 1'b0;
    i_rx_valid  = '0;
    i_rx_sop    = '0;
    i_rx_eop    = '0;
    i_rx_data   = '0;
    i_rx_user   = '0;
    test_reset();
    test_aligned();
    test_split_single();
    test_split_multi();
    test_random();
    idle(2);
    test_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
